// File: rtl/gemm_tile_scheduler.sv
// Tile-walking control FSM for the GEMM datapath: issues A/B reads per k step,
// strobes the MAC accumulators, then drains each finished tile into SRAM C.
module gemm_tile_scheduler #(
  parameter int TileM         = 4,
  parameter int TileN         = 4,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int CPerWord      = 4,
  localparam int WordsPerRow  = TileN / CPerWord,
  localparam int RowW         = (TileM > 1) ? $clog2(TileM) : 1,
  localparam int WordW        = (WordsPerRow > 1) ? $clog2(WordsPerRow) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     acc_en_o,
  output logic                     acc_clr_o,
  output logic [RowW-1:0]          wr_row_o,
  output logic [WordW-1:0]         wr_word_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int SW     = SizeAddrWidth;
  localparam int ProdW  = 2 * SizeAddrWidth + AddrWidth + 8;
  localparam int LogTM  = $clog2(TileM);
  localparam int LogTN  = $clog2(TileN);
  localparam int LogCPW = $clog2(CPerWord);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state, w_next_state;

  logic [SW-1:0]    r_m, r_k, r_n;
  logic [SW-1:0]    r_mt_tot, r_nt_tot, r_cs;
  logic [SW-1:0]    r_mt, r_nt, r_kcnt;
  logic [RowW-1:0]  r_row;
  logic [WordW-1:0] r_word;
  logic             r_acc_en, r_acc_clr;

  // Tile counts and C row stride, rounded up from the raw sizes at start.
  logic [SW:0]   w_m_round, w_n_round, w_cs_round;
  logic [SW-1:0] w_mt_tot, w_nt_tot, w_cs;
  logic          w_zero_size;

  assign w_m_round   = {1'b0, M_size_i} + (SW+1)'(TileM - 1);
  assign w_n_round   = {1'b0, N_size_i} + (SW+1)'(TileN - 1);
  assign w_cs_round  = {1'b0, N_size_i} + (SW+1)'(CPerWord - 1);
  assign w_mt_tot    = SW'(w_m_round >> LogTM);
  assign w_nt_tot    = SW'(w_n_round >> LogTN);
  assign w_cs        = SW'(w_cs_round >> LogCPW);
  assign w_zero_size = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

  logic w_last_k, w_last_word, w_last_row, w_tile_end, w_last_nt, w_last_mt;

  assign w_last_k    = (r_kcnt == r_k - SW'(1));
  assign w_last_word = (r_word == WordW'(WordsPerRow - 1));
  assign w_last_row  = (r_row == RowW'(TileM - 1));
  assign w_tile_end  = w_last_word && w_last_row;
  assign w_last_nt   = (r_nt == r_nt_tot - SW'(1));
  assign w_last_mt   = (r_mt == r_mt_tot - SW'(1));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned -- that is what keeps combinational blocks from inferring latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next_state = w_zero_size ? S_DONE : S_LOAD;
      S_LOAD:  if (w_last_k) w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_WRITE;
      S_WRITE: if (w_tile_end) w_next_state = (w_last_nt && w_last_mt) ? S_DONE : S_LOAD;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m       <= '0;
      r_k       <= '0;
      r_n       <= '0;
      r_mt_tot  <= '0;
      r_nt_tot  <= '0;
      r_cs      <= '0;
      r_mt      <= '0;
      r_nt      <= '0;
      r_kcnt    <= '0;
      r_row     <= '0;
      r_word    <= '0;
      r_acc_en  <= 1'b0;
      r_acc_clr <= 1'b0;
    end else begin
      // Read data lags the address by one cycle, so the strobes do too.
      r_acc_en  <= (r_state == S_LOAD);
      r_acc_clr <= (r_state == S_LOAD) && (r_kcnt == '0);
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_m      <= M_size_i;
            r_k      <= K_size_i;
            r_n      <= N_size_i;
            r_mt_tot <= w_mt_tot;
            r_nt_tot <= w_nt_tot;
            r_cs     <= w_cs;
            r_mt     <= '0;
            r_nt     <= '0;
            r_kcnt   <= '0;
            r_row    <= '0;
            r_word   <= '0;
          end
        end
        S_LOAD: r_kcnt <= w_last_k ? '0 : r_kcnt + SW'(1);
        S_WAIT: begin
          r_row  <= '0;
          r_word <= '0;
        end
        S_WRITE: begin
          if (w_last_word) begin
            r_word <= '0;
            r_row  <= w_last_row ? '0 : r_row + RowW'(1);
          end else begin
            r_word <= r_word + WordW'(1);
          end
          if (w_tile_end) begin
            if (w_last_nt) begin
              r_nt <= '0;
              r_mt <= r_mt + SW'(1);
            end else begin
              r_nt <= r_nt + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic             w_in_load, w_in_write;
  logic [ProdW-1:0] w_c_row, w_c_col;
  logic [AddrWidth-1:0] w_a_addr, w_b_addr, w_c_addr;

  assign w_in_load  = (r_state == S_LOAD);
  assign w_in_write = (r_state == S_WRITE);

  // Full-width products, then wrap to the SRAM address width.
  assign w_a_addr = AddrWidth'(ProdW'(r_mt) * ProdW'(r_k) + ProdW'(r_kcnt));
  assign w_b_addr = AddrWidth'(ProdW'(r_kcnt) * ProdW'(r_nt_tot) + ProdW'(r_nt));
  assign w_c_row  = (ProdW'(r_mt) << LogTM) + ProdW'(r_row);
  assign w_c_col  = (ProdW'(r_nt) << LogTN) + (ProdW'(r_word) << LogCPW);
  assign w_c_addr = AddrWidth'(w_c_row * ProdW'(r_cs)
                  + ProdW'(r_nt) * ProdW'(WordsPerRow) + ProdW'(r_word));

  assign sram_a_addr_o = w_in_load  ? w_a_addr : '0;
  assign sram_b_addr_o = w_in_load  ? w_b_addr : '0;
  assign sram_c_addr_o = w_in_write ? w_c_addr : '0;
  assign sram_c_we_o   = w_in_write && (w_c_row < ProdW'(r_m)) && (w_c_col < ProdW'(r_n));
  assign wr_row_o      = w_in_write ? r_row  : '0;
  assign wr_word_o     = w_in_write ? r_word : '0;
  assign acc_en_o      = r_acc_en;
  assign acc_clr_o     = r_acc_clr;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);

endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
Control FSM that sequences the GEMM datapath. It walks output tiles of TileM rows by TileN columns over M×K×N matrices and issues SRAM A/B read addresses for each k step. It drives the accumulator clear/enable strobes for the MAC array, then drains each finished tile into SRAM C one 128-bit word (4 × int32) per cycle. It sits between the top-level start/size interface and the MAC/PE array inside gemm_accelerator_top.

Parameters:
TileM, 4, rows per tile; equals A elements per SRAM A word; power of 2, 1..16
TileN, 4, columns per tile; equals B elements per SRAM B word; power of 2, multiple of 4
AddrWidth, 12, SRAM address width
SizeAddrWidth, 8, width of the M/K/N size inputs
CPerWord, 4, int32 results per SRAM C word (fixed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start request; sampled only in IDLE
M_size_i  in  SizeAddrWidth  rows of A/C
K_size_i  in  SizeAddrWidth  inner dimension
N_size_i  in  SizeAddrWidth  columns of B/C
sram_a_addr_o  out  AddrWidth  A read address
sram_b_addr_o  out  AddrWidth  B read address
sram_c_addr_o  out  AddrWidth  C write address
sram_c_we_o  out  1  C write enable
acc_en_o  out  1  A/B read data valid this cycle; array must accumulate
acc_clr_o  out  1  with acc_en_o on k=0; array loads the product instead of accumulating
wr_row_o  out  $clog2(TileM) (min 1)  tile row the array presents for writing
wr_word_o  out  $clog2(TileN/4) (min 1)  word-in-row the array presents
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values, and values in IDLE: all outputs 0. Reset in any state returns to IDLE the next cycle. Reset aborts with no done_o and no further C writes.
- Sizes are latched when start_i is accepted. Size inputs are ignored at all other times. start_i while busy is ignored.
- Derived values:
  - MT = ceil(M/TileM)
  - NT = ceil(N/TileN)
  - CS = ceil(N/4), the C row stride
  - W = TileM·TileN/4, write cycles per tile
- SRAM reads have 1-cycle latency. Address issued in cycle t gives data in t+1.
- FSM states: IDLE, LOAD, WAIT, WRITE, DONE.
- IDLE: on start_i, go to LOAD. If any of M, K, N is 0, go directly to DONE with no memory accesses.
- LOAD: K cycles for the current tile (mt, nt), k = 0..K-1.
  - sram_a_addr_o = mt·K + k
  - sram_b_addr_o = k·NT + nt
  - After k = K-1, go to WAIT.
- acc_en_o is a 1-cycle-delayed copy of "in LOAD". acc_clr_o is a 1-cycle-delayed copy of "in LOAD and k = 0".
- WAIT: one cycle; the last data arrives (acc_en_o = 1). Then go to WRITE.
- WRITE: W cycles. Row r = 0..TileM-1 is the outer index and word w = 0..TileN/4-1 the inner index.
  - wr_row_o = r, wr_word_o = w
  - sram_c_addr_o = (mt·TileM + r)·CS + nt·(TileN/4) + w
  - sram_c_we_o = 1 only if (mt·TileM + r) < M and (nt·TileN + 4w) < N. Padding rows and columns still consume their cycle but are not written.
  - The array presents data combinationally from wr_row_o/wr_word_o in the same cycle.
- Tile order: nt is the inner loop, mt the outer loop. After the last write of a tile, go straight to LOAD of the next tile, with no bubble. After the last tile, go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE. A start_i in the DONE cycle is ignored.
- Latency: with start accepted at edge 0, done_o is high in cycle MT·NT·(K+1+W) + 1.
- Address arithmetic uses enough internal width for the full products and is truncated to AddrWidth (wraps modulo 2^AddrWidth). Range checking is the caller's responsibility.
- sram_a_addr_o, sram_b_addr_o and sram_c_addr_o are 0 outside LOAD and WRITE respectively.

Test Plan:
1. M=4, K=64, N=16, defaults: MT=1, NT=4, each tile 69 cycles. done_o in cycle 277. 16 C writes at addresses 0..15, each written exactly once. A addresses 0..63 repeated 4 times. B addresses for tile nt = 4k+nt.
2. M=16, K=64, N=4: MT=4, NT=1. C addresses 0..15, one per row. At tile mt=2, k=5: A addr = 133, B addr = 5. done_o in cycle 277.
3. M=3, K=2, N=6, TileN=4: NT=2, CS=2. Row 3 is never written, and neither is word col 8 (tile nt=1, w... suppressed only if ≥N). Exactly 6 C writes: addresses 0,1,2,3,4,5. done_o in cycle 2·(2+1+4)+1 = 15.
4. Per tile: acc_clr_o is high exactly on the first acc_en_o cycle, and acc_en_o is high for exactly K consecutive cycles. K=1 gives clr+en in the WAIT cycle only.
5. K=0 → done_o in cycle 1, no we/en. start_i held high during a run and during the DONE cycle → no restart, and sizes are not re-latched mid-run.
6. rst_i asserted mid-LOAD → next cycle all outputs 0, busy_o=0, no done_o. A new start then runs correctly from tile (0,0).
